// File: rtl/traverse_ctrl.sv
// -----------------------------------------------------------------------------
// traverse_ctrl
// Walks a (2*RV+1) x (2*RH+1) window around the current centre pixel, issuing
// one tap offset per cycle to a fixed-latency mask datapath. It tracks the
// in-flight taps and accumulates the weights and weighted channels returned by
// the datapath. A one-cycle done pulse follows the last accumulation.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a traversal (accepted only in IDLE)
//   stall            : line buffer not ready, freeze tap issue
//   busy             : traversal in progress (ISSUE or DRAIN)
//   calc_en          : tap issue strobe to the mask datapath
//   ii_ofs, jj_ofs   : signed row and column offset of the issued tap
//   ii_diff, jj_diff : magnitude of ii_ofs and jj_ofs
//   wtmp             : tap weight returned by the datapath
//   imosum_part      : four weighted channels returned (channel 3 in MSBs)
//   wsum, imosum     : accumulated weight and four accumulated channels
//   done             : one-cycle completion pulse
// -----------------------------------------------------------------------------
module traverse_ctrl #(
    parameter int unsigned DW_IN  = 10,
    parameter int unsigned DW_DEC = 8,
    parameter int unsigned RV     = 6,
    parameter int unsigned RH     = 12,
    parameter int unsigned LAT    = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stall,
    output logic                        busy,
    output logic                        calc_en,
    output logic [3:0]                  ii_ofs,
    output logic [4:0]                  jj_ofs,
    output logic [2:0]                  ii_diff,
    output logic [3:0]                  jj_diff,
    input  logic [DW_DEC:0]             wtmp,
    input  logic [DW_IN*4-1:0]          imosum_part,
    output logic [DW_DEC+9:0]           wsum,
    output logic [(DW_IN+9)*4-1:0]      imosum,
    output logic                        done
);

    localparam int unsigned WS_W  = DW_DEC + 10;
    localparam int unsigned ACC_W = DW_IN + 9;
    localparam int unsigned CNT_W = 6;
    localparam int          RV_I  = int'(RV);
    localparam int          RH_I  = int'(RH);

    localparam logic signed [3:0] II_FIRST = 4'(-RV_I);
    localparam logic signed [3:0] II_LAST  = 4'(RV_I);
    localparam logic signed [4:0] JJ_FIRST = 5'(-RH_I);
    localparam logic signed [4:0] JJ_LAST  = 5'(RH_I);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic signed [3:0]          r_ti;       // next tap row to issue
    logic signed [4:0]          r_tj;       // next tap column to issue
    logic                       r_calc_en;
    logic [3:0]                 r_ii;
    logic [4:0]                 r_jj;
    logic [2:0]                 r_iid;
    logic [3:0]                 r_jjd;
    logic                       r_busy;
    logic                       r_done;
    logic [WS_W-1:0]            r_wsum;
    logic [ACC_W*4-1:0]         r_imosum;
    logic [LAT-1:0]             r_vld;
    logic [CNT_W-1:0]           r_outst;

    logic [2:0]                 w_ti_abs;
    logic [3:0]                 w_tj_abs;
    logic                       w_last_tap;
    logic                       w_res_vld;

    assign w_ti_abs   = r_ti[3] ? 3'(-r_ti) : 3'(r_ti);
    assign w_tj_abs   = r_tj[4] ? 4'(-r_tj) : 4'(r_tj);
    assign w_last_tap = (r_ti == II_LAST) && (r_tj == JJ_LAST);
    assign w_res_vld  = r_vld[LAT-1];

    // Traversal FSM, result tracking and accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ti      <= '0;
            r_tj      <= '0;
            r_calc_en <= 1'b0;
            r_ii      <= '0;
            r_jj      <= '0;
            r_iid     <= '0;
            r_jjd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wsum    <= '0;
            r_imosum  <= '0;
            r_vld     <= '0;
            r_outst   <= '0;
        end else begin
            r_calc_en <= 1'b0;
            r_done    <= 1'b0;

            // Result valid pipe runs regardless of stall and state
            r_vld <= {r_vld[LAT-2:0], r_calc_en};

            case ({r_calc_en, w_res_vld})
                2'b10:   r_outst <= r_outst + CNT_W'(1);
                2'b01:   r_outst <= r_outst - CNT_W'(1);
                default: r_outst <= r_outst;
            endcase

            if (w_res_vld) begin
                r_wsum <= r_wsum + WS_W'(wtmp);
                for (int k = 0; k < 4; k++) begin
                    r_imosum[k*ACC_W +: ACC_W] <= r_imosum[k*ACC_W +: ACC_W]
                        + ACC_W'(imosum_part[k*DW_IN +: DW_IN]);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_ISSUE;
                        r_busy   <= 1'b1;
                        r_ti     <= II_FIRST;
                        r_tj     <= JJ_FIRST;
                        r_ii     <= II_FIRST;
                        r_jj     <= JJ_FIRST;
                        r_iid    <= 3'(RV);
                        r_jjd    <= 4'(RH);
                        r_wsum   <= '0;
                        r_imosum <= '0;
                        r_outst  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        r_calc_en <= 1'b1;
                        r_ii      <= r_ti;
                        r_jj      <= r_tj;
                        r_iid     <= w_ti_abs;
                        r_jjd     <= w_tj_abs;
                        if (w_last_tap) begin
                            r_state <= S_DRAIN;
                        end else if (r_tj == JJ_LAST) begin
                            r_tj <= JJ_FIRST;
                            r_ti <= r_ti + 4'sd1;
                        end else begin
                            r_tj <= r_tj + 5'sd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last issued tap is not yet in r_outst while r_calc_en is high
                    if ((r_outst == '0) && !w_res_vld && !r_calc_en) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign calc_en = r_calc_en;
    assign ii_ofs  = r_ii;
    assign jj_ofs  = r_jj;
    assign ii_diff = r_iid;
    assign jj_diff = r_jjd;
    assign wsum    = r_wsum;
    assign imosum  = r_imosum;
    assign done    = r_done;

endmodule

// File: tb/tb_traverse_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traverse_ctrl
// Directed bench for traverse_ctrl: reset state, scan order on a 3x3 window,
// nominal run, stalled run, start while busy, reset during drain, and
// back-to-back runs. A small datapath model returns results LAT cycles after
// each calc_en and drives junk otherwise.
// -----------------------------------------------------------------------------
module tb_traverse_ctrl;

    localparam int unsigned LAT  = 14;
    localparam int          RV   = 6;
    localparam int          RH   = 12;
    localparam int          NTAP = (2*RV+1)*(2*RH+1);

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stall;
    logic        busy, calc_en, done;
    logic [3:0]  ii_ofs;
    logic [4:0]  jj_ofs;
    logic [2:0]  ii_diff;
    logic [3:0]  jj_diff;
    logic [8:0]  wtmp;
    logic [39:0] imosum_part;
    logic [17:0] wsum;
    logic [75:0] imosum;

    logic        start_s;
    logic        busy_s, calc_en_s, done_s;
    logic [3:0]  ii_ofs_s;
    logic [4:0]  jj_ofs_s;
    logic [2:0]  ii_diff_s;
    logic [3:0]  jj_diff_s;
    logic [17:0] wsum_s;
    logic [75:0] imosum_s;

    int n_assert = 0;
    int n_fail   = 0;

    // Datapath model: returns the programmed result LAT cycles after calc_en
    logic [8:0]     w_val    = '0;
    logic [39:0]    part_val = '0;
    logic [LAT-1:0] dp_pipe  = '0;
    always @(posedge clk) dp_pipe <= {dp_pipe[LAT-2:0], calc_en};
    assign wtmp        = dp_pipe[LAT-1] ? w_val    : 9'h1a5;
    assign imosum_part = dp_pipe[LAT-1] ? part_val : 40'ha55a5a5a5a;

    // Expected 3x3 scan
    int sii [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    int sjj [9] = '{-1,  0,  1,-1, 0, 1,-1, 0, 1};
    int sid [9] = '{ 1,  1,  1, 0, 0, 0, 1, 1, 1};
    int sjd [9] = '{ 1,  0,  1, 1, 0, 1, 1, 0, 1};

    traverse_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .busy        (busy),
        .calc_en     (calc_en),
        .ii_ofs      (ii_ofs),
        .jj_ofs      (jj_ofs),
        .ii_diff     (ii_diff),
        .jj_diff     (jj_diff),
        .wtmp        (wtmp),
        .imosum_part (imosum_part),
        .wsum        (wsum),
        .imosum      (imosum),
        .done        (done)
    );

    traverse_ctrl #(.RV(1), .RH(1), .LAT(2)) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_s),
        .stall       (1'b0),
        .busy        (busy_s),
        .calc_en     (calc_en_s),
        .ii_ofs      (ii_ofs_s),
        .jj_ofs      (jj_ofs_s),
        .ii_diff     (ii_diff_s),
        .jj_diff     (jj_diff_s),
        .wtmp        (9'd1),
        .imosum_part (40'd0),
        .wsum        (wsum_s),
        .imosum      (imosum_s),
        .done        (done_s)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_calc_en"}, calc_en, 0);
        chk({tag, "_done"},    done,    0);
        chk({tag, "_offsets"}, {ii_ofs, jj_ofs, ii_diff, jj_diff}, 0);
        chk({tag, "_wsum"},    wsum,    0);
        chk({tag, "_imosum"},  imosum,  0);
    endtask

    task automatic scan_small();
        int          n   = 0;
        int          cyc = 0;
        bit          gd  = 0;
        logic [15:0] e;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        while (!gd && cyc < 100) begin
            if (calc_en_s) begin
                if (n < 9) begin
                    e = {4'(sii[n]), 5'(sjj[n]), 3'(sid[n]), 4'(sjd[n])};
                    chk($sformatf("scan_tap%0d", n),
                        {ii_ofs_s, jj_ofs_s, ii_diff_s, jj_diff_s}, e);
                end
                n++;
            end
            if (done_s) gd = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("scan_done_seen", gd, 1);
        chk("scan_ntap", n, 9);
        chk("scan_wsum", wsum_s, 9);
        chk("scan_imosum", imosum_s, 0);
    endtask

    // mode: 0 nominal, 1 stalls, 2 start while busy, 3 reset during drain
    task automatic run(input string tag, input logic [8:0] w, input logic [39:0] part,
                       input int mode);
        int          cyc = 0, n_calc = 0, seq_err = 0, busy_err = 0, post_err = 0;
        int          done_cyc = 0, stall_left = 0;
        int          exp_i = -RV, exp_j = -RH;
        bit          got_done = 0, prev_stall = 0;
        logic [3:0]  ei;
        logic [4:0]  ej;
        logic [2:0]  eid;
        logic [3:0]  ejd;
        logic [17:0] exp_ws;
        logic [75:0] exp_imo;
        w_val    = w;
        part_val = part;
        exp_ws   = 18'(NTAP * int'(w));
        for (int k = 0; k < 4; k++) exp_imo[k*19 +: 19] = 19'(NTAP * int'(part[k*10 +: 10]));

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_accept_busy"}, busy, 1);
        chk({tag, "_accept_clear"}, wsum, 0);

        while (!got_done && cyc < 2000) begin
            if (calc_en) begin
                ei  = 4'(exp_i);
                ej  = 5'(exp_j);
                eid = 3'(exp_i < 0 ? -exp_i : exp_i);
                ejd = 4'(exp_j < 0 ? -exp_j : exp_j);
                if ({ii_ofs, jj_ofs, ii_diff, jj_diff} !== {ei, ej, eid, ejd} || prev_stall)
                    seq_err++;
                n_calc++;
                if (exp_j == RH) begin
                    exp_j = -RH;
                    exp_i++;
                end else begin
                    exp_j++;
                end
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end else if (busy !== 1'b1) begin
                busy_err++;
            end
            start = (mode == 2 && (cyc == 100 || cyc == 330));
            if (stall_left > 0) stall_left--;
            if (mode == 1 && calc_en && n_calc == 40)       stall_left = 5;
            if (mode == 1 && calc_en && n_calc == NTAP - 1) stall_left = 1;
            stall      = (stall_left > 0);
            prev_stall = stall;
            if (mode == 3 && cyc == 330) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outs({tag, "_async"});
                return;
            end
            if (!got_done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        stall = 1'b0;

        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_n_calc"}, n_calc, NTAP);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_busy_err"}, busy_err, 0);
        if (mode != 1)
            chk({tag, "_done_window"}, (done_cyc >= NTAP + LAT && done_cyc <= NTAP + LAT + 2), 1);
        chk({tag, "_wsum"}, wsum, exp_ws);
        chk({tag, "_imosum"}, imosum, exp_imo);
        chk({tag, "_busy_at_done"}, busy, 0);

        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_hold_wsum"}, wsum, exp_ws);
        if (mode == 2) begin
            for (int c = 0; c < 6; c++) begin
                if (done || calc_en || busy) post_err++;
                @(posedge clk); #1;
            end
            chk({tag, "_no_second_run"}, post_err, 0);
            chk({tag, "_hold_imosum"}, imosum, exp_imo);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        start_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        scan_small();

        run("nominal", 9'd256, {4{10'd100}}, 0);
        run("stall",   9'd256, {4{10'd100}}, 1);
        run("busy_start", 9'd256, {4{10'd100}}, 2);

        run("rst_drain", 9'd256, {4{10'd100}}, 3);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("rst_held");
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_wsum", wsum, 0);
        chk("post_reset_imosum", imosum, 0);
        chk("post_reset_busy", busy, 0);
        run("after_rst", 9'd256, {4{10'd100}}, 0);

        run("b2b_run1", 9'd256, {4{10'd100}}, 0);
        chk("b2b_run1_visible_wsum", wsum, 83200);
        chk("b2b_run1_visible_imosum", imosum, {4{19'd32500}});
        run("b2b_run2", 9'd1, {10'd4, 10'd3, 10'd2, 10'd1}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traverse_ctrl.md
TRAVERSE_CTRL -- requirements
Module: traverse_ctrl

Interface
- REQ-001 Parameters (name, default, meaning):
  - DW_IN, 10: pixel channel width.
  - DW_DEC, 8: weight fraction width; weights are (DW_DEC+1) bits and 1.0 = 2^DW_DEC.
  - RV, 6: vertical window radius, 1..6.
  - RH, 12: horizontal window radius, 1..12.
  - LAT, 14: fixed mask-datapath latency in clk cycles, from calc_en to result, 2..31.
- REQ-002 Ports (name, direction, width, meaning):
  - clk, in, 1: clock.
  - rst_n, in, 1: reset; asynchronous, active-low.
  - start, in, 1: begin one window traversal for the current centre pixel.
  - stall, in, 1: upstream line buffer not ready; freeze tap issue.
  - busy, out, 1: traversal in progress.
  - calc_en, out, 1: tap issue strobe to the mask datapath.
  - ii_ofs, out, 4: signed row offset of the tap.
  - jj_ofs, out, 5: signed column offset of the tap.
  - ii_diff, out, 3: |ii_ofs|.
  - jj_diff, out, 4: |jj_ofs|.
  - wtmp, in, DW_DEC+1: tap weight returned by the datapath.
  - imosum_part, in, DW_IN*4: four weighted channels returned by the datapath; channel 3 is in the MSBs.
  - wsum, out, DW_DEC+10: accumulated weight.
  - imosum, out, (DW_IN+9)*4: four accumulated channels; channel 3 is in the MSBs.
  - done, out, 1: one-cycle completion pulse.

Function
- REQ-003 FSM states: IDLE, ISSUE, DRAIN, DONE. Reset state is IDLE.
- REQ-004 IDLE -> ISSUE on start=1.
  - Same edge: ii_ofs=-RV, jj_ofs=-RH, wsum=0, imosum=0, outstanding-tap counter=0.
- REQ-005 start is ignored in every state other than IDLE.
- REQ-006 ISSUE, stall=0: each cycle emits one tap.
  - calc_en=1 with registered ii_ofs/jj_ofs/ii_diff/jj_diff, all changing on the same edge.
  - Scan is row-major: jj_ofs -RH..+RH, then ii_ofs increments and jj_ofs wraps to -RH.
- REQ-007 ISSUE, stall=1: calc_en=0 and the offsets hold.
  - Issue resumes at the same tap when stall falls; no tap is skipped or duplicated.
- REQ-008 After tap (+RV,+RH) is issued, ISSUE -> DRAIN; total taps = (2RV+1)*(2RH+1), which is 325 at defaults.
- REQ-009 calc_en=0 in all states except ISSUE.
- REQ-010 Result tracking:
  - A LAT-deep valid shift register is loaded with calc_en and advances every cycle, independent of stall and state.
  - The result is valid when bit LAT-1 is set.
- REQ-011 On a valid result: wsum += wtmp; imosum[k] += imosum_part[k] for k=0..3, each unsigned.
  - Widths are sized so 325 maximum taps cannot overflow; no saturation logic.
- REQ-012 Outstanding counter: +1 per calc_en, -1 per valid result, unchanged when both occur.
- REQ-013 DRAIN -> DONE when outstanding=0 and no result is valid that cycle.
  - The final accumulation has therefore landed before DONE.
- REQ-014 DONE: done=1 for exactly one cycle, then -> IDLE.
- REQ-015 wsum/imosum hold their final values from DONE until the next accepted start.
- REQ-016 busy=1 in ISSUE and DRAIN; busy=0 in IDLE and DONE.
- REQ-017 Per-tap diff values: ii_diff<=6 and jj_diff<=12, so ii_diff*ii_diff + jj_diff*jj_diff <= 180, within the datapath's 8-bit distance input.

Reset
- REQ-018 rst_n=0 asynchronously forces, regardless of current state or outstanding taps:
  - state=IDLE;
  - calc_en=0, busy=0, done=0;
  - ii_ofs=0, jj_ofs=0, ii_diff=0, jj_diff=0;
  - wsum=0, imosum=0;
  - valid shift register and outstanding counter = 0.
- REQ-019 After release, the block waits for a new start; results in flight from before reset are never accumulated.

Verification
- REQ-020 Nominal run (defaults, stall=0): start pulse, datapath model returns wtmp=256 and each imosum_part channel=100 exactly LAT cycles after each calc_en.
  - Required: 325 calc_en cycles, then done at cycle 325+LAT+1 after start (±1 per design doc).
  - Required: wsum=83200, each imosum channel=32500.
- REQ-021 Scan order (RV=1, RH=1): record the issued (ii_ofs, jj_ofs) pairs.
  - Required sequence: (-1,-1)(-1,0)(-1,1)(0,-1)(0,0)(0,1)(1,-1)(1,0)(1,1).
  - Required diffs: ii_diff 1,1,1,0,0,0,1,1,1; jj_diff 1,0,1 repeating.
- REQ-022 Stall: stall=1 for 5 cycles at tap 40, and for 1 cycle at the last tap.
  - Required: calc_en count 325, no duplicate or missing pairs, sums identical to REQ-020.
- REQ-023 Start while busy: start pulses during ISSUE and during DRAIN.
  - Required: ignored; exactly one done, sums unchanged.
- REQ-024 Reset mid-DRAIN: assert rst_n=0 with 10 taps outstanding, release, then start a new run.
  - Required: all outputs 0 immediately on reset; new run sums equal REQ-020 with no contamination from the old run.
- REQ-025 Back-to-back runs: start asserted in the cycle after done, with run 2 using wtmp=1.
  - Required: run 2 result wsum=325; run 1 values visible until run 2's start is accepted.
